// File: rtl/matmul_operand_sp_pkg.sv
// Shared definitions for the matmul operand scratchpad: operand codes,
// dimension/index-width helpers and the handshake FSM state type.
package matmul_operand_sp_pkg;

  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] OPERAND_A = 5'b00100;
  localparam logic [OP_W-1:0] OPERAND_B = 5'b01000;
  localparam logic [OP_W-1:0] OPERAND_C = 5'b10000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sp_state_e;

  function automatic int max_dim(input int data_w, input int bus_w);
    return bus_w / data_w;
  endfunction

  // Never returns 0 so degenerate depths still get a legal index vector.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matmul_operand_sp_if.sv
// Host and engine-side signal bundle of the matmul operand scratchpad.
interface matmul_operand_sp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
);
  localparam int NF = (BUS_WIDTH / DATA_WIDTH) * (BUS_WIDTH / DATA_WIDTH);

  logic                  host_we_i;
  logic                  host_re_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [BUS_WIDTH-1:0]  host_wdata_i;
  logic [BUS_WIDTH-1:0]  host_rdata_o;
  logic                  host_rvalid_o;
  logic                  host_start_i;
  logic                  host_mode_i;
  logic                  start_o;
  logic                  mode_o;
  logic [BUS_WIDTH-1:0]  data_a_o;
  logic [BUS_WIDTH-1:0]  data_b_o;
  logic [BUS_WIDTH-1:0]  data_c_o;
  logic                  enable_w_i;
  logic [ADDR_WIDTH-1:0] address_i;
  logic [BUS_WIDTH-1:0]  data_i;
  logic                  finish_mul_i;
  logic [NF-1:0]         flags_i;
  logic [NF-1:0]         flags_o;
  logic                  done_o;
  logic                  err_o;

  modport master (
    output host_we_i, host_re_i, host_addr_i, host_wdata_i, host_start_i, host_mode_i,
           enable_w_i, address_i, data_i, finish_mul_i, flags_i,
    input  host_rdata_o, host_rvalid_o, start_o, mode_o, data_a_o, data_b_o, data_c_o,
           flags_o, done_o, err_o
  );

  modport slave (
    input  host_we_i, host_re_i, host_addr_i, host_wdata_i, host_start_i, host_mode_i,
           enable_w_i, address_i, data_i, finish_mul_i, flags_i,
    output host_rdata_o, host_rvalid_o, start_o, mode_o, data_a_o, data_b_o, data_c_o,
           flags_o, done_o, err_o
  );
endinterface

// File: rtl/matmul_operand_sp_bank.sv
// DEPTH x WIDTH register bank: one write port, one combinational read port
// and one registered read port (read-before-write on a same-index write).
module sp_bank
  import matmul_operand_sp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16,
  localparam int AW   = idx_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    craddr_i,
  output logic [WIDTH-1:0] crdata_o,
  input  logic             re_i,
  input  logic [AW-1:0]    qraddr_i,
  output logic [WIDTH-1:0] qrdata_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem      <= '0;
      qrdata_o <= '0;
    end else begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) qrdata_o <= mem[qraddr_i];
    end
  end

  assign crdata_o = mem[craddr_i];
endmodule

// File: rtl/matmul_operand_sp.sv
// Operand/result scratchpad facing the matmul engine. Optional feature
// SP_RESULT_AS_BIAS_EN: captured results are also written into the C-bias bank.
module matmul_operand_sp
  import matmul_operand_sp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_ni,
  matmul_operand_sp_if.slave sp
);
  localparam int MAX_DIM = max_dim(DATA_WIDTH, BUS_WIDTH);
  localparam int NC      = MAX_DIM * MAX_DIM;
  localparam int IW_AB   = idx_w(MAX_DIM);
  localparam int IW_C    = idx_w(NC);

  sp_state_e state_q, state_d;
  logic go, fin;
  logic [IW_AB-1:0] rd_ptr_ab;
  logic [IW_C-1:0]  rd_ptr_c;
  logic [NC-1:0]    mask_q, mask_nxt;
  logic [OP_W-1:0]  rd_sel_q;

  wire [OP_W-1:0]  host_op  = sp.host_addr_i[OP_W-1:0];
  wire [OP_W-1:0]  eng_op   = sp.address_i[OP_W-1:0];
  wire [IW_AB-1:0] h_idx_ab = sp.host_addr_i[OP_W +: IW_AB];
  wire [IW_C-1:0]  h_idx_c  = sp.host_addr_i[OP_W +: IW_C];
  wire [IW_C-1:0]  e_idx_c  = sp.address_i[OP_W +: IW_C];
  wire             unused_addr = ^{sp.host_addr_i, sp.address_i};

  wire wr_ok     = (state_q != BUSY);
  wire wr_a      = sp.host_we_i && wr_ok && host_op == OPERAND_A;
  wire wr_b      = sp.host_we_i && wr_ok && host_op == OPERAND_B;
  wire wr_c_host = sp.host_we_i && wr_ok && host_op == OPERAND_C;
  wire host_err  = sp.host_we_i && (!wr_ok ||
                   !(host_op inside {OPERAND_A, OPERAND_B, OPERAND_C}));
  wire eng_hit   = sp.enable_w_i && eng_op == OPERAND_C;
  wire eng_err   = sp.enable_w_i && (eng_op != OPERAND_C || state_q != BUSY);

  assign mask_nxt = mask_q | (eng_hit ? (NC'(1) << e_idx_c) : '0);

  // Free-running stream pointers; the engine keeps identical counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_ab <= '0;
      rd_ptr_c  <= '0;
    end else begin
      rd_ptr_ab <= (rd_ptr_ab == IW_AB'(MAX_DIM - 1)) ? '0 : rd_ptr_ab + 1'b1;
      rd_ptr_c  <= (rd_ptr_c == IW_C'(NC - 1)) ? '0 : rd_ptr_c + 1'b1;
    end
  end

  logic                 c_we;
  logic [IW_C-1:0]      c_waddr;
  logic [BUS_WIDTH-1:0] c_wdata;
`ifdef SP_RESULT_AS_BIAS_EN
  // Engine write wins over a colliding host bias write.
  assign c_we    = wr_c_host || eng_hit;
  assign c_waddr = eng_hit ? e_idx_c : h_idx_c;
  assign c_wdata = eng_hit ? sp.data_i : sp.host_wdata_i;
`else
  assign c_we    = wr_c_host;
  assign c_waddr = h_idx_c;
  assign c_wdata = sp.host_wdata_i;
`endif

  logic [BUS_WIDTH-1:0] data_a, data_b, data_c, rq_a, rq_b, rq_r;
  logic [BUS_WIDTH-1:0] unused_c_q, unused_r_c;

  sp_bank #(.DEPTH(MAX_DIM), .WIDTH(BUS_WIDTH)) u_bank_a (
    .clk_i, .rst_ni, .we_i(wr_a), .waddr_i(h_idx_ab), .wdata_i(sp.host_wdata_i),
    .craddr_i(rd_ptr_ab), .crdata_o(data_a),
    .re_i(sp.host_re_i && host_op == OPERAND_A), .qraddr_i(h_idx_ab), .qrdata_o(rq_a));

  sp_bank #(.DEPTH(MAX_DIM), .WIDTH(BUS_WIDTH)) u_bank_b (
    .clk_i, .rst_ni, .we_i(wr_b), .waddr_i(h_idx_ab), .wdata_i(sp.host_wdata_i),
    .craddr_i(rd_ptr_ab), .crdata_o(data_b),
    .re_i(sp.host_re_i && host_op == OPERAND_B), .qraddr_i(h_idx_ab), .qrdata_o(rq_b));

  sp_bank #(.DEPTH(NC), .WIDTH(BUS_WIDTH)) u_bank_c (
    .clk_i, .rst_ni, .we_i(c_we), .waddr_i(c_waddr), .wdata_i(c_wdata),
    .craddr_i(rd_ptr_c), .crdata_o(data_c),
    .re_i(1'b0), .qraddr_i('0), .qrdata_o(unused_c_q));

  sp_bank #(.DEPTH(NC), .WIDTH(BUS_WIDTH)) u_bank_r (
    .clk_i, .rst_ni, .we_i(eng_hit), .waddr_i(e_idx_c), .wdata_i(sp.data_i),
    .craddr_i('0), .crdata_o(unused_r_c),
    .re_i(sp.host_re_i && host_op == OPERAND_C), .qraddr_i(h_idx_c), .qrdata_o(rq_r));

  assign sp.data_a_o = data_a;
  assign sp.data_b_o = data_b;
  assign sp.data_c_o = data_c;

  always_comb begin
    sp.host_rdata_o = '0;
    case (rd_sel_q)
      OPERAND_A: sp.host_rdata_o = rq_a;
      OPERAND_B: sp.host_rdata_o = rq_b;
      OPERAND_C: sp.host_rdata_o = rq_r;
      default:   sp.host_rdata_o = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE, DONE: if (sp.host_start_i) begin state_d = BUSY; go = 1'b1; end
      BUSY:       if (sp.finish_mul_i) begin state_d = DONE; fin = 1'b1; end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      sp.start_o       <= 1'b0;
      sp.mode_o        <= 1'b0;
      sp.done_o        <= 1'b0;
      sp.err_o         <= 1'b0;
      sp.flags_o       <= '0;
      sp.host_rvalid_o <= 1'b0;
      rd_sel_q         <= '0;
      mask_q           <= '0;
    end else begin
      state_q          <= state_d;
      sp.host_rvalid_o <= sp.host_re_i;
      if (sp.host_re_i) rd_sel_q <= host_op;
      mask_q <= go ? '0 : mask_nxt;
      if (go) begin
        sp.start_o <= 1'b1;
        sp.mode_o  <= sp.host_mode_i;
        sp.done_o  <= 1'b0;
      end
      if (fin) begin
        sp.start_o <= 1'b0;
        sp.done_o  <= 1'b1;
        sp.flags_o <= sp.flags_i;
      end
      if (host_err || eng_err || (fin && !(&mask_nxt))) sp.err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matmul_operand_sp.sv
// Directed bench for matmul_operand_sp (MAX_DIM=2) with a spec-level model.
module tb_matmul_operand_sp;
  import matmul_operand_sp_pkg::*;
  localparam int DW = 8, BW = 16, AW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int errors = 0, checks = 0;

  matmul_operand_sp_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();
  matmul_operand_sp #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sp(bus));

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: banks as plain arrays, handshake as a few flags.
  logic [15:0] mA[2], mB[2], mC[4], mR[4];
  logic [15:0] m_rd;
  logic [3:0]  m_flags, m_written;
  bit m_busy, m_start, m_mode, m_done, m_err, m_rv;
  int cyc;
  logic [4:0] hop, eop;
  int hi2, hi4, ei4;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin mA[i] = 0; mB[i] = 0; end
      for (int i = 0; i < 4; i++) begin mC[i] = 0; mR[i] = 0; end
      m_rd = 0; m_flags = 0; m_written = 0; cyc = 0;
      m_busy = 0; m_start = 0; m_mode = 0; m_done = 0; m_err = 0; m_rv = 0;
    end else begin
      cyc++;
      hop = bus.host_addr_i[4:0];
      eop = bus.address_i[4:0];
      hi2 = int'(bus.host_addr_i[5]);
      hi4 = int'(bus.host_addr_i[6:5]);
      ei4 = int'(bus.address_i[6:5]);
      m_rv = bus.host_re_i;
      if (bus.host_re_i)
        m_rd = (hop == OPERAND_A) ? mA[hi2] : (hop == OPERAND_B) ? mB[hi2] :
               (hop == OPERAND_C) ? mR[hi4] : 16'h0;
      if (bus.host_we_i) begin
        if (m_busy) m_err = 1;
        else if (hop == OPERAND_A) mA[hi2] = bus.host_wdata_i;
        else if (hop == OPERAND_B) mB[hi2] = bus.host_wdata_i;
        else if (hop == OPERAND_C) mC[hi4] = bus.host_wdata_i;
        else m_err = 1;
      end
      if (bus.enable_w_i) begin
        if (!m_busy) m_err = 1;
        if (eop == OPERAND_C) begin
          mR[ei4] = bus.data_i;
          m_written[ei4] = 1'b1;
`ifdef SP_RESULT_AS_BIAS_EN
          mC[ei4] = bus.data_i;
`endif
        end else m_err = 1;
      end
      if (!m_busy && bus.host_start_i) begin
        m_busy = 1; m_start = 1; m_mode = bus.host_mode_i; m_written = 0; m_done = 0;
      end else if (m_busy && bus.finish_mul_i) begin
        m_busy = 0; m_start = 0; m_done = 1; m_flags = bus.flags_i;
        if (m_written != 4'hf) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      chk("data_a", bus.data_a_o, mA[cyc % 2]);
      chk("data_b", bus.data_b_o, mB[cyc % 2]);
      chk("data_c", bus.data_c_o, mC[cyc % 4]);
      chk("start", bus.start_o, m_start);
      chk("mode", bus.mode_o, m_mode);
      chk("done", bus.done_o, m_done);
      chk("err", bus.err_o, m_err);
      chk("flags", bus.flags_o, m_flags);
      chk("rvalid", bus.host_rvalid_o, m_rv);
      if (m_rv) chk("rdata", bus.host_rdata_o, m_rd);
    end
  end

  // Tasks are entered on a negedge and return on the following negedge.
  task automatic hwrite(input logic [4:0] op, input int idx, input logic [15:0] d);
    bus.host_we_i = 1; bus.host_addr_i = (AW'(idx) << 5) | AW'(op); bus.host_wdata_i = d;
    @(negedge clk);
    bus.host_we_i = 0;
  endtask

  task automatic hread(input logic [4:0] op, input int idx, input logic [15:0] exp, input string nm);
    bus.host_re_i = 1; bus.host_addr_i = (AW'(idx) << 5) | AW'(op);
    @(negedge clk);
    bus.host_re_i = 0;
    chk(nm, bus.host_rdata_o, exp);
    chk({nm, "_vld"}, bus.host_rvalid_o, 1);
  endtask

  task automatic ewrite(input logic [4:0] op, input int idx, input logic [15:0] d);
    bus.enable_w_i = 1; bus.address_i = (AW'(idx) << 5) | AW'(op); bus.data_i = d;
    @(negedge clk);
    bus.enable_w_i = 0;
  endtask

  task automatic finish(input logic [3:0] f);
    bus.finish_mul_i = 1; bus.flags_i = f;
    @(negedge clk);
    bus.finish_mul_i = 0; bus.flags_i = 0;
  endtask

  task automatic start(input bit mode);
    bus.host_start_i = 1; bus.host_mode_i = mode;
    @(negedge clk);
    bus.host_start_i = 0; bus.host_mode_i = 0;
  endtask

  logic [15:0] a0, a1;

  initial begin
    bus.host_we_i = 0; bus.host_re_i = 0; bus.host_addr_i = 0; bus.host_wdata_i = 0;
    bus.host_start_i = 0; bus.host_mode_i = 0; bus.enable_w_i = 0; bus.address_i = 0;
    bus.data_i = 0; bus.finish_mul_i = 0; bus.flags_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_start", bus.start_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_flags", bus.flags_o, 0);
    chk("rst_rdata", bus.host_rdata_o, 0);
    chk("rst_rvalid", bus.host_rvalid_o, 0);
    rst_ni = 1;

    hwrite(OPERAND_A, 0, 16'h0201);
    hwrite(OPERAND_A, 1, 16'h0403);
    hwrite(OPERAND_B, 0, 16'h0605);
    hwrite(OPERAND_B, 1, 16'h0807);
    for (int i = 0; i < 4; i++) hwrite(OPERAND_C, i, 16'h0010 + 16'(i));
    hread(OPERAND_A, 1, 16'h0403, "rd_a1");

    start(1'b0);
    chk("start_hi", bus.start_o, 1);
    a0 = bus.data_a_o;
    @(negedge clk);
    a1 = bus.data_a_o;
    chk("a_alternates", (a0 == 16'h0201 && a1 == 16'h0403) || (a0 == 16'h0403 && a1 == 16'h0201), 1);

    for (int i = 0; i < 4; i++) ewrite(OPERAND_C, i, 16'(5 + i));
    finish(4'b0010);
    chk("fin_done", bus.done_o, 1);
    chk("fin_flags", bus.flags_o, 4'b0010);
    chk("fin_err", bus.err_o, 0);
    chk("fin_start", bus.start_o, 0);
    for (int i = 0; i < 4; i++) hread(OPERAND_C, i, 16'(5 + i), "rd_res");
`ifdef SP_RESULT_AS_BIAS_EN
    for (int i = 0; i < 4; i++) begin
      chk("bias_from_res", bus.data_c_o, 32'(5 + (cyc % 4)));
      @(negedge clk);
    end
`endif

    start(1'b1);
    chk("mode_hi", bus.mode_o, 1);
    hwrite(OPERAND_A, 0, 16'hdead);
    ewrite(OPERAND_A, 0, 16'hbeef);
    chk("busy_err", bus.err_o, 1);
    hread(OPERAND_A, 0, 16'h0201, "a0_kept");
    hread(OPERAND_C, 0, 16'h0005, "r0_kept");

    #2 rst_ni = 0;
    #1;
    chk("arst_start", bus.start_o, 0);
    chk("arst_done", bus.done_o, 0);
    chk("arst_err", bus.err_o, 0);
    chk("arst_a", bus.data_a_o, 0);
    chk("arst_b", bus.data_b_o, 0);
    @(negedge clk);
    rst_ni = 1;

    hwrite(OPERAND_A, 0, 16'h1111);
    start(1'b0);
    for (int i = 0; i < 3; i++) ewrite(OPERAND_C, i, 16'(9 + i));
    finish(4'b0000);
    chk("part_done", bus.done_o, 1);
    chk("part_err", bus.err_o, 1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matmul_operand_sp.md
Name: matmul_operand_sp

Overview:
- Scratchpad responder on the far side of the matmul calc engine's operand and result interface.
- Holds A/B operand rows and C-bias elements, loaded by the host. Streams them to the engine on its free-running row/element schedule.
- Captures the engine's result write stream (address, data, write-enable) into a result bank, which the host reads back.
- Owns the start/finish handshake with the engine.

Parameters:
- DATA_WIDTH, 8, element width.
- BUS_WIDTH, 16, word width; one A/B row = MAX_DIM elements = one word.
- ADDR_WIDTH, 32, address width.
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, matrix dimension.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- host_we_i  in  1  host write strobe.
- host_re_i  in  1  host read strobe.
- host_addr_i  in  ADDR_WIDTH  host address. [4:0] selects the operand: 00100 A, 01000 B, 10000 C. Bits above [4:0] hold the index.
- host_wdata_i  in  BUS_WIDTH  host write data.
- host_rdata_o  out  BUS_WIDTH  host read data.
- host_rvalid_o  out  1  read data valid.
- host_start_i  in  1  start pulse.
- host_mode_i  in  1  bias-enable request, sampled at start.
- start_o  out  1  engine start.
- mode_o  out  1  engine mode (add C bias).
- data_a_o, data_b_o  out  BUS_WIDTH  streamed A/B rows.
- data_c_o  out  BUS_WIDTH  streamed C-bias element.
- enable_w_i  in  1  engine result write enable.
- address_i  in  ADDR_WIDTH  engine result address.
- data_i  in  BUS_WIDTH  engine result data.
- finish_mul_i  in  1  engine finish pulse.
- flags_i  in  MAX_DIM*MAX_DIM  engine overflow flags.
- flags_o  out  MAX_DIM*MAX_DIM  latched overflow flags.
- done_o  out  1  result ready.
- err_o  out  1  sticky error.

Behaviour:
- Reset (asynchronous, active-low): clears all banks, pointers and the FSM.
  - Outputs 0: start_o, mode_o, done_o, err_o, host_rvalid_o, flags_o, host_rdata_o.
  - FSM to IDLE.
- Stream pointers:
  - rd_ptr_ab (log2 MAX_DIM bits) and rd_ptr_c (2*log2 MAX_DIM bits) reset to 0.
  - Both increment every cycle. rd_ptr_ab wraps at MAX_DIM-1; rd_ptr_c wraps at MAX_DIM^2-1.
  - data_a_o = A[rd_ptr_ab] and data_b_o = B[rd_ptr_ab], combinational. Alignment with the engine's own counters relies on both sides leaving reset in the same cycle.
  - data_c_o = Cbias[rd_ptr_c], combinational.
- Host write, in IDLE or DONE only:
  - Writes A[idx] or B[idx] (idx = addr[5+:log2 MAX_DIM]), or Cbias[idx] (idx = addr[5+:2*log2 MAX_DIM]).
  - Any other operand code: ignored and sets err_o.
  - Host write while BUSY: ignored and sets err_o.
- Host read, any state:
  - host_rdata_o is registered with 1-cycle latency; host_rvalid_o pulses with it.
  - Operand C returns Result[idx]. A and B return the operand banks.
  - A read in the same cycle as an engine write to the same index returns the old value (read-before-write).
- Result capture:
  - When enable_w_i is high and address_i[4:0] = 10000, Result[address_i index] <= data_i and written-mask bit idx is set.
  - enable_w_i with any other operand code sets err_o and leaves Result unchanged.
  - enable_w_i outside BUSY sets err_o.
- FSM:
  - IDLE: on host_start_i, go to BUSY. Set start_o=1, mode_o=host_mode_i, clear the written mask and done_o.
  - BUSY: start_o held high. On finish_mul_i, go to DONE; deassert start_o the next cycle; flags_o <= flags_i; done_o=1. If the written mask is not all ones at finish, err_o is set.
  - DONE: on host_start_i, go to BUSY with the same actions as IDLE. host_start_i in BUSY is ignored.
- err_o clears only on reset.

Optional Feature:
- Macro: SP_RESULT_AS_BIAS_EN.
- Defined: every captured result write also writes Cbias[idx], so the next start with mode=1 accumulates onto the previous result. On a simultaneous host Cbias write to the same index, the engine write wins.
- Undefined: Cbias is written by the host only.

Decomposition:
- Shared package holds:
  - OPERAND_A/B/C codes and the operand-field width (5).
  - MAX_DIM derivation and index-width helpers.
  - FSM state typedef (IDLE, BUSY, DONE).
- One sub-module, sp_bank: parameterised depth × BUS_WIDTH register bank with one write port and two read ports (one combinational, one registered). Instantiated for A, B, Cbias and Result.

Test Plan:
All scenarios use MAX_DIM=2.
- Host writes A[0]=0x0201 and A[1]=0x0403, then reads A[1] → host_rdata_o=0x0403 one cycle after host_re_i, with host_rvalid_o=1.
- Load A and B, then host_start_i with mode=0 → start_o=1 next cycle. data_a_o alternates 0x0201/0x0403 in step with rd_ptr_ab.
- Engine writes C0..C3 = 5, 6, 7, 8, then finish_mul_i with flags_i=4'b0010 → done_o=1, flags_o=0010, err_o=0. Host reads of C return 5..8.
- Only 3 result writes before finish_mul_i → done_o=1 and err_o=1.
- Host write during BUSY, and enable_w_i with address_i[4:0]=00100 → neither write takes effect; err_o=1.
- Assert rst_ni low mid-BUSY → start_o, done_o and banks are 0 asynchronously. With SP_RESULT_AS_BIAS_EN defined, after a completed run data_c_o streams the captured results 5..8.
